// File: rtl/reg_dst_mux_pkg.sv
// Shared definitions for the MIPS write-destination register selector.
package reg_dst_mux_pkg;

  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : reg_dst_mux_pkg

// File: rtl/reg_dst_mux.sv
// Two-way register-address selector with a same-cycle result and a registered copy.
module reg_dst_mux
  import reg_dst_mux_pkg::*;
#(
  parameter int               WIDTH     = REG_ADDR_W,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q
);

  // The conditional operator merges a and b bitwise when sel is unknown,
  // so agreeing bits stay known instead of the whole result going X.
  assign y = sel ? b : a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= RESET_VAL;
    end else if (en) begin
      y_q <= y;
    end
  end

endmodule : reg_dst_mux

// File: tb/tb_reg_dst_mux.sv
// Directed self-checking bench for reg_dst_mux: combinational select, enabled capture, async reset.
module tb_reg_dst_mux;

  logic       clk;
  logic       rst_n;
  logic [4:0] a;
  logic [4:0] b;
  logic       sel;
  logic       en;
  logic [4:0] y;
  logic [4:0] y_q;

  int checkCount = 0;
  int errorCount = 0;

  reg_dst_mux #(
    .WIDTH    (5),
    .RESET_VAL(5'b00000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a    (a),
    .b    (b),
    .sel  (sel),
    .en   (en),
    .y    (y),
    .y_q  (y_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [4:0] observed, input logic [4:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b, expected %b", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] aVal, input logic [4:0] bVal, input logic selVal);
    a   = aVal;
    b   = bVal;
    sel = selVal;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    a     = 5'b00000;
    b     = 5'b00000;
    sel   = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_yq", y_q, 5'b00000);
    checkOutput("reset_y", y, 5'b00000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_hold_en0", y_q, 5'b00000);

    // sel=1 picks b, then capture it
    @(negedge clk);
    applyStimulus(5'b01010, 5'b10101, 1'b1);
    checkOutput("sel1_y", y, 5'b10101);
    checkOutput("comb_before_edge_yq", y_q, 5'b00000);
    en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("capture_b_yq", y_q, 5'b10101);

    @(negedge clk);
    en = 1'b0;
    applyStimulus(5'b00000, 5'b10101, 1'b1);
    checkOutput("a_change_ignored", y, 5'b10101);
    applyStimulus(5'b00000, 5'b11111, 1'b1);
    checkOutput("b_change_follows", y, 5'b11111);
    applyStimulus(5'b00101, 5'b11111, 1'b1);
    checkOutput("a_change_ignored2", y, 5'b11111);
    @(posedge clk);
    #1;
    checkOutput("en0_holds_yq", y_q, 5'b10101);

    @(negedge clk);
    applyStimulus(5'b00101, 5'b11101, 1'b0);
    checkOutput("sel0_y", y, 5'b00101);
    en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("capture_a_yq", y_q, 5'b00101);

    // Unknown select: only the bits where a and b agree have a defined value
    @(negedge clk);
    en = 1'b0;
    applyStimulus(5'b00101, 5'b11101, 1'bx);
    checkOutput("selx_agree_bits", {2'b00, y[2:0]}, 5'b00101);
    applyStimulus(5'b00101, 5'b11101, 1'b0);

    // Assert reset between edges: y_q clears at once, y keeps tracking inputs
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_yq", y_q, 5'b00000);
    checkOutput("reset_y_unaffected", y, 5'b00101);
    applyStimulus(5'b10001, 5'b11101, 1'b0);
    checkOutput("reset_y_tracks", y, 5'b10001);
    en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_overrides_en", y_q, 5'b00000);

    @(negedge clk);
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("release_en0_hold", y_q, 5'b00000);

    @(negedge clk);
    applyStimulus(5'b10001, 5'b10101, 1'b1);
    en = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("first_capture_after_reset", y_q, 5'b10101);

    @(negedge clk);
    en = 1'b0;
    applyStimulus(5'b01110, 5'b00011, 1'b0);
    checkOutput("final_sel0_y", y, 5'b01110);
    @(posedge clk);
    #1;
    checkOutput("final_hold_yq", y_q, 5'b10101);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_reg_dst_mux

// File: doc/reg_dst_mux.md
Name: reg_dst_mux

Overview:
- Two-input, 5-bit-wide selector for the MIPS pipeline.
- Chooses between two register-address candidates (for example rt and rd for the write-destination field).
- Provides a combinational result for same-cycle use and a registered copy for the next pipeline stage.
- Flop stage uses one clock and an asynchronous active-low reset.

Parameters:
- WIDTH, 5, bit width of data inputs and outputs (register-file address width).
- RESET_VAL, 0, value loaded into y_q while reset is asserted.

Ports:
- clk  input  1  single clock; y_q updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; clears y_q immediately on assertion.
- a  input  WIDTH  candidate 0.
- b  input  WIDTH  candidate 1.
- sel  input  1  select: 0 picks a, 1 picks b.
- en  input  1  load enable for y_q; 1 = capture y on the clock edge.
- y  output  WIDTH  combinational mux result.
- y_q  output  WIDTH  registered mux result.

Behaviour:
- y is purely combinational with zero latency:
  - sel=0 -> y=a.
  - sel=1 -> y=b.
  - Any change on a, b or sel propagates within the same delta/cycle.
- Unknown select: when sel is X or Z, y follows ternary-merge semantics.
  - Each bit where a and b agree outputs that common value.
  - Each bit where they differ outputs X.
  - Never force y to all-X or all-0 for an unknown sel.
- y does not depend on clk, rst_n or en.
- y_q, reset:
  - rst_n low -> y_q = RESET_VAL immediately, without waiting for clk.
  - Held while rst_n is low.
- y_q, normal operation:
  - Rising clk with rst_n high and en=1 -> y_q takes the value of y. Latency is 1 cycle.
  - en=0 -> y_q holds its value.
- Reset deasserted: the first capture happens on the first rising clk where rst_n is high and en=1.
- Reset asserted mid-operation: it overrides any pending capture. y is unaffected by reset.
- No arithmetic, no width extension: all of a, b, y and y_q are exactly WIDTH bits.

Decomposition:
- Shared package holds REG_ADDR_W = 5 (register-address width). WIDTH defaults to it.
- No sub-module.
- Combinational select and output flop live in the same module as two separate processes: one combinational assignment and one async-reset flop.

Test Plan:
- a=01010, b=10101, sel=1 -> y=10101. After a rising clk with en=1, y_q=10101.
- Then a=00000, sel still 1 -> y stays 10101.
- Then b=11111 -> y=11111.
- Then a=00101 -> y=11111.
- Then sel=0 together with b=11101 -> y=00101. Next enabled edge -> y_q=00101.
- Then sel=X with a=00101, b=11101 -> y=xx101 (bits 2:0 agree, bits 4:3 differ).
- Reset: with y_q=00101, drive rst_n=0 between clock edges -> y_q=00000 at once, while y still tracks the inputs.
- Reset release: deassert rst_n with en=0 -> y_q holds 00000 across edges. Set en=1, sel=1, b=10101 -> y_q=10101 after one edge.
